// File: rtl/display_ctrl_if.sv
// Handshake bundle between a game controller and display_ctrl: event pulses in,
// registered message-select and status out.
interface display_ctrl_if;
  logic       iniciar;
  logic       nivel_in;
  logic       venceu;
  logic       perdeu;
  logic       limpar;
  logic [1:0] displayAddr;
  logic       nivel;
  logic       ocupado;

  modport master (
    output iniciar, nivel_in, venceu, perdeu, limpar,
    input  displayAddr, nivel, ocupado
  );

  modport slave (
    input  iniciar, nivel_in, venceu, perdeu, limpar,
    output displayAddr, nivel, ocupado
  );
endinterface

// File: rtl/display_ctrl.sv
// Display message sequencer: level banner with hold timer, then win/lose message.
// Define DISPLAY_CTRL_BLINK_EN to blink the win/lose message every BLINK_CYCLES.
module display_ctrl #(
  parameter int HOLD_CYCLES  = 50000000,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic          clock,
  input  logic          reset,
  display_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    BANNER  = 3'd1,
    JOGO    = 3'd2,
    VITORIA = 3'd3,
    DERROTA = 3'd4
  } state_t;

  localparam logic [25:0] HOLD_M1  = 26'(HOLD_CYCLES - 1);
  // The counter never needs to exceed the larger terminal count, so it parks there.
  localparam logic [25:0] CNT_CEIL =
    26'(((HOLD_CYCLES > BLINK_CYCLES) ? HOLD_CYCLES : BLINK_CYCLES) - 1);
`ifdef DISPLAY_CTRL_BLINK_EN
  localparam logic [25:0] BLINK_M1 = 26'(BLINK_CYCLES - 1);
`endif

  state_t      state_q,   state_d;
  logic [25:0] counter_q, counter_d;
  logic [1:0]  addr_q,    addr_d;
  logic        nivel_q,   nivel_d;
  logic        ocupado_q, ocupado_d;
  logic        phase_q,   phase_d;
  logic [25:0] cnt_inc_s;
  logic        playing_s;

  assign cnt_inc_s = (counter_q >= CNT_CEIL) ? counter_q : counter_q + 26'd1;
  assign playing_s = (state_q == BANNER) || (state_q == JOGO);

  // Next-state and next-output decode, events in priority order.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    addr_d    = addr_q;
    nivel_d   = nivel_q;
    ocupado_d = ocupado_q;
    phase_d   = phase_q;
    if (bus.limpar) begin
      state_d   = OCIOSO;
      counter_d = 26'd0;
      addr_d    = 2'b11;
      ocupado_d = 1'b0;
      phase_d   = 1'b1;
    end else if (bus.perdeu && playing_s) begin
      state_d   = DERROTA;
      counter_d = 26'd0;
      addr_d    = 2'b10;
      ocupado_d = 1'b0;
      phase_d   = 1'b1;
    end else if (bus.venceu && playing_s) begin
      state_d   = VITORIA;
      counter_d = 26'd0;
      addr_d    = 2'b01;
      ocupado_d = 1'b0;
      phase_d   = 1'b1;
    end else if (bus.iniciar && (playing_s || (state_q == OCIOSO))) begin
      state_d   = BANNER;
      counter_d = 26'd0;
      addr_d    = 2'b00;
      nivel_d   = bus.nivel_in;
      ocupado_d = 1'b1;
    end else begin
      case (state_q)
        BANNER: begin
          if (counter_q == HOLD_M1) begin
            state_d   = JOGO;
            counter_d = 26'd0;
            addr_d    = 2'b11;
            ocupado_d = 1'b0;
          end else begin
            counter_d = cnt_inc_s;
          end
        end
`ifdef DISPLAY_CTRL_BLINK_EN
        VITORIA, DERROTA: begin
          if (counter_q == BLINK_M1) begin
            counter_d = 26'd0;
            phase_d   = ~phase_q;
          end else begin
            counter_d = cnt_inc_s;
          end
          if (!phase_d) begin
            addr_d = 2'b11;
          end else if (state_q == DERROTA) begin
            addr_d = 2'b10;
          end else begin
            addr_d = 2'b01;
          end
        end
`endif
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= OCIOSO;
      counter_q <= 26'd0;
      addr_q    <= 2'b11;
      nivel_q   <= 1'b0;
      ocupado_q <= 1'b0;
      phase_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      addr_q    <= addr_d;
      nivel_q   <= nivel_d;
      ocupado_q <= ocupado_d;
      phase_q   <= phase_d;
    end
  end

  assign bus.displayAddr = addr_q;
  assign bus.nivel       = nivel_q;
  assign bus.ocupado     = ocupado_q;

endmodule

// File: tb/tb_display_ctrl.sv
// Directed self-checking bench for display_ctrl with HOLD_CYCLES=4, BLINK_CYCLES=3.
module tb_display_ctrl;
  logic clock;
  logic reset;
  int   total;
  int   bad;

  display_ctrl_if bus ();

  display_ctrl #(
    .HOLD_CYCLES (4),
    .BLINK_CYCLES(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] e_addr, input logic e_nivel,
                     input logic e_ocup);
    total++;
    assert (bus.displayAddr === e_addr) else begin
      bad++;
      $error("FAIL %s displayAddr got=%b exp=%b", tag, bus.displayAddr, e_addr);
    end
    total++;
    assert (bus.nivel === e_nivel) else begin
      bad++;
      $error("FAIL %s nivel got=%b exp=%b", tag, bus.nivel, e_nivel);
    end
    total++;
    assert (bus.ocupado === e_ocup) else begin
      bad++;
      $error("FAIL %s ocupado got=%b exp=%b", tag, bus.ocupado, e_ocup);
    end
  endtask

  initial begin
    logic [1:0] exp_addr;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.iniciar  = 1'b0;
    bus.nivel_in = 1'b0;
    bus.venceu   = 1'b0;
    bus.perdeu   = 1'b0;
    bus.limpar   = 1'b0;
    step();
    step();
    chk("reset_hold", 2'b11, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("idle_after_reset", 2'b11, 1'b0, 1'b0);

    // Banner with nivel_in=1, hold of 4 cycles
    bus.nivel_in = 1'b1;
    bus.iniciar  = 1'b1;
    step();
    bus.iniciar  = 1'b0;
    chk("banner_k", 2'b00, 1'b1, 1'b1);
    step();
    chk("banner_k1", 2'b00, 1'b1, 1'b1);
    step();
    step();
    chk("banner_k3", 2'b00, 1'b1, 1'b1);
    step();
    chk("jogo_k4", 2'b11, 1'b1, 1'b0);
    step();
    chk("jogo_k5", 2'b11, 1'b1, 1'b0);

    // Banner restart at k+2 with nivel_in=0
    bus.iniciar = 1'b1;
    step();
    bus.iniciar = 1'b0;
    chk("restart_k", 2'b00, 1'b1, 1'b1);
    step();
    bus.nivel_in = 1'b0;
    bus.iniciar  = 1'b1;
    step();
    bus.iniciar  = 1'b0;
    chk("restart_k2", 2'b00, 1'b0, 1'b1);
    step();
    step();
    step();
    chk("restart_k5", 2'b00, 1'b0, 1'b1);
    step();
    chk("restart_k6", 2'b11, 1'b0, 1'b0);

    // venceu+perdeu together in JOGO: perdeu wins, terminal state holds
    bus.venceu = 1'b1;
    bus.perdeu = 1'b1;
    step();
    bus.venceu = 1'b0;
    bus.perdeu = 1'b0;
    chk("both_lose", 2'b10, 1'b0, 1'b0);
    bus.venceu = 1'b1;
    step();
    bus.venceu = 1'b0;
    chk("late_win_ignored", 2'b10, 1'b0, 1'b0);
    bus.nivel_in = 1'b1;
    bus.iniciar  = 1'b1;
    step();
    bus.iniciar  = 1'b0;
    chk("start_in_derrota", 2'b10, 1'b0, 1'b0);
    bus.limpar = 1'b1;
    step();
    bus.limpar = 1'b0;
    chk("limpar_derrota", 2'b11, 1'b0, 1'b0);

    // limpar beats iniciar; nivel holds
    bus.iniciar = 1'b1;
    step();
    chk("banner_again", 2'b00, 1'b1, 1'b1);
    bus.limpar = 1'b1;
    step();
    bus.limpar  = 1'b0;
    bus.iniciar = 1'b0;
    chk("limpar_prio", 2'b11, 1'b1, 1'b0);
    bus.venceu = 1'b1;
    step();
    bus.venceu = 1'b0;
    chk("win_in_idle", 2'b11, 1'b1, 1'b0);

    // Win during BANNER, blink pattern (or steady message)
    bus.iniciar = 1'b1;
    step();
    bus.iniciar = 1'b0;
    bus.venceu  = 1'b1;
    step();
    bus.venceu  = 1'b0;
    chk("win_k", 2'b01, 1'b1, 1'b0);
    for (int c = 1; c < 8; c++) begin
      step();
`ifdef DISPLAY_CTRL_BLINK_EN
      exp_addr = ((c / 3) % 2 == 0) ? 2'b01 : 2'b11;
`else
      exp_addr = 2'b01;
`endif
      chk($sformatf("win_blink_%0d", c), exp_addr, 1'b1, 1'b0);
    end
    bus.limpar = 1'b1;
    step();
    bus.limpar = 1'b0;
    chk("limpar_vitoria", 2'b11, 1'b1, 1'b0);

    // Asynchronous reset mid-BANNER
    bus.nivel_in = 1'b1;
    bus.iniciar  = 1'b1;
    step();
    bus.iniciar  = 1'b0;
    chk("pre_reset_banner", 2'b00, 1'b1, 1'b1);
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", 2'b11, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    step();
    chk("post_reset_1", 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("post_reset_6", 2'b11, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
